// File: rtl/ps2_mouse_ctrl.sv
// rtl/ps2_mouse_ctrl.sv - PS/2 mouse init sequencer and packet-to-position assembler
// Drives reset/rate/enable commands, then turns 3-byte packets into clamped cursor coordinates.
module ps2_mouse_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES     = 2_500_000,
  parameter int unsigned BAT_TIMEOUT_CYCLES = 75_000_000,
  parameter int unsigned MAX_RETRIES        = 3,
  parameter int unsigned HOLDOFF_CYCLES     = 25_000_000,
  parameter logic [7:0]  SAMPLE_RATE        = 8'd100,
  parameter int unsigned X_MAX              = 639,
  parameter int unsigned Y_MAX              = 479,
  parameter int unsigned X_INIT             = 320,
  parameter int unsigned Y_INIT             = 240
) (
  input  logic        clk,
  input  logic        resetn,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        rx_err,
  output logic [11:0] mouse_x_pos,
  output logic [11:0] mouse_y_pos,
  output logic [2:0]  buttons,
  output logic        new_event,
  output logic        mouse_err,
  output logic        streaming
);

  typedef enum logic [3:0] {
    S_RST_SEND, S_RST_ACK, S_RST_BAT, S_RST_ID, S_RATE_CMD, S_RATE_CMD_ACK,
    S_RATE_VAL, S_RATE_VAL_ACK, S_EN_SEND, S_EN_ACK, S_STREAM, S_ERROR
  } state_t;

  localparam logic signed [13:0] X_LIM = 14'(X_MAX);
  localparam logic signed [13:0] Y_LIM = 14'(Y_MAX);

  state_t      state_q, state_d, next_state;
  logic [1:0]  rst_sync_q, rst_sync_d;
  logic        tx_valid_q, tx_valid_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic [31:0] cnt_q, cnt_d, limit;
  logic [7:0]  retry_q, retry_d;
  logic        err_q, err_d;
  logic [1:0]  idx_q, idx_d;
  logic [6:0]  hdr_q, hdr_d;
  logic [7:0]  b1_q, b1_d;
  logic [11:0] x_q, x_d, y_q, y_d, x_new, y_new;
  logic [2:0]  btn_q, btn_d;
  logic        evt_q, evt_d;
  logic        is_send, is_expect, fail;
  logic [7:0]  send_byte, expect_byte;
  logic signed [13:0] dx, dy, x_sum, y_sum;

  // Header is stored without its always-one bit3: {yovf, xovf, ysign, xsign, M, R, L}.
  always_comb begin
    dx    = hdr_q[5] ? 14'sd0 : {{5{hdr_q[3]}}, hdr_q[3], b1_q};
    dy    = hdr_q[6] ? 14'sd0 : {{5{hdr_q[4]}}, hdr_q[4], rx_data};
    x_sum = $signed({2'b00, x_q}) + dx;
    y_sum = $signed({2'b00, y_q}) - dy;
    if (x_sum < 14'sd0)     x_new = 12'd0;
    else if (x_sum > X_LIM) x_new = 12'(X_MAX);
    else                    x_new = x_sum[11:0];
    if (y_sum < 14'sd0)     y_new = 12'd0;
    else if (y_sum > Y_LIM) y_new = 12'(Y_MAX);
    else                    y_new = y_sum[11:0];
  end

  always_comb begin
    rst_sync_d  = {rst_sync_q[0], 1'b1};
    state_d     = state_q;
    tx_valid_d  = tx_valid_q;
    tx_data_d   = tx_data_q;
    cnt_d       = cnt_q + 32'd1;
    retry_d     = retry_q;
    err_d       = err_q;
    idx_d       = idx_q;
    hdr_d       = hdr_q;
    b1_d        = b1_q;
    x_d         = x_q;
    y_d         = y_q;
    btn_d       = btn_q;
    evt_d       = 1'b0;
    is_send     = 1'b0;
    is_expect   = 1'b0;
    fail        = 1'b0;
    send_byte   = 8'h00;
    expect_byte = 8'h00;
    next_state  = state_q;
    limit       = TIMEOUT_CYCLES;
    case (state_q)
      S_RST_SEND:     begin is_send = 1'b1; send_byte = 8'hFF; next_state = S_RST_ACK; end
      S_RST_ACK:      begin is_expect = 1'b1; expect_byte = 8'hFA; next_state = S_RST_BAT; end
      S_RST_BAT:      begin is_expect = 1'b1; expect_byte = 8'hAA; next_state = S_RST_ID;
                            limit = BAT_TIMEOUT_CYCLES; end
      S_RST_ID:       begin is_expect = 1'b1; expect_byte = 8'h00; next_state = S_RATE_CMD; end
      S_RATE_CMD:     begin is_send = 1'b1; send_byte = 8'hF3; next_state = S_RATE_CMD_ACK; end
      S_RATE_CMD_ACK: begin is_expect = 1'b1; expect_byte = 8'hFA; next_state = S_RATE_VAL; end
      S_RATE_VAL:     begin is_send = 1'b1; send_byte = SAMPLE_RATE; next_state = S_RATE_VAL_ACK; end
      S_RATE_VAL_ACK: begin is_expect = 1'b1; expect_byte = 8'hFA; next_state = S_EN_SEND; end
      S_EN_SEND:      begin is_send = 1'b1; send_byte = 8'hF4; next_state = S_EN_ACK; end
      S_EN_ACK:       begin is_expect = 1'b1; expect_byte = 8'hFA; next_state = S_STREAM; end
      default:        ;
    endcase

    if (is_send) begin
      cnt_d = 32'd0;
      if (!tx_valid_q) begin
        if (rst_sync_q[1]) begin
          tx_valid_d = 1'b1;
          tx_data_d  = send_byte;
        end
      end else if (tx_ready) begin
        tx_valid_d = 1'b0;
        state_d    = next_state;
      end
    end else if (is_expect) begin
      // An arriving byte takes precedence over a coincident timeout.
      if (rx_err) fail = 1'b1;
      else if (rx_valid) begin
        if (rx_data == expect_byte) begin
          state_d = next_state;
          cnt_d   = 32'd0;
        end else fail = 1'b1;
      end else if (cnt_q == limit - 32'd1) fail = 1'b1;
      if (fail) begin
        retry_d = retry_q + 8'd1;
        err_d   = 1'b1;
        cnt_d   = 32'd0;
        state_d = ({24'd0, retry_q} + 32'd1 <= MAX_RETRIES) ? S_RST_SEND : S_ERROR;
      end
      if (state_d == S_STREAM) begin
        retry_d = 8'd0;
        err_d   = 1'b0;
        idx_d   = 2'd0;
      end
    end else if (state_q == S_ERROR) begin
      if (cnt_q == HOLDOFF_CYCLES - 32'd1) begin
        retry_d = 8'd0;
        cnt_d   = 32'd0;
        state_d = S_RST_SEND;
      end
    end else begin
      if (idx_q == 2'd0) cnt_d = 32'd0;
      if (rx_err) begin
        idx_d = 2'd0;
        cnt_d = 32'd0;
      end else if (rx_valid) begin
        cnt_d = 32'd0;
        case (idx_q)
          2'd0: if (rx_data[3]) begin
            hdr_d = {rx_data[7:4], rx_data[2:0]};
            idx_d = 2'd1;
          end
          2'd1: begin
            b1_d  = rx_data;
            idx_d = 2'd2;
          end
          default: begin
            x_d   = x_new;
            y_d   = y_new;
            btn_d = hdr_q[2:0];
            evt_d = 1'b1;
            idx_d = 2'd0;
          end
        endcase
      end else if (idx_q != 2'd0 && cnt_q == TIMEOUT_CYCLES - 32'd1) begin
        idx_d = 2'd0;
        cnt_d = 32'd0;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rst_sync_q <= 2'b00;
      state_q    <= S_RST_SEND;
      tx_valid_q <= 1'b0;
      tx_data_q  <= 8'h00;
      cnt_q      <= 32'd0;
      retry_q    <= 8'd0;
      err_q      <= 1'b0;
      idx_q      <= 2'd0;
      hdr_q      <= 7'd0;
      b1_q       <= 8'd0;
      x_q        <= 12'(X_INIT);
      y_q        <= 12'(Y_INIT);
      btn_q      <= 3'd0;
      evt_q      <= 1'b0;
    end else begin
      rst_sync_q <= rst_sync_d;
      state_q    <= state_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      cnt_q      <= cnt_d;
      retry_q    <= retry_d;
      err_q      <= err_d;
      idx_q      <= idx_d;
      hdr_q      <= hdr_d;
      b1_q       <= b1_d;
      x_q        <= x_d;
      y_q        <= y_d;
      btn_q      <= btn_d;
      evt_q      <= evt_d;
    end
  end

  assign tx_data     = tx_data_q;
  assign tx_valid    = tx_valid_q;
  assign mouse_x_pos = x_q;
  assign mouse_y_pos = y_q;
  assign buttons     = btn_q;
  assign new_event   = evt_q;
  assign mouse_err   = err_q;
  assign streaming   = (state_q == S_STREAM);

endmodule
